// File: rtl/freepdk45_sram_1w1r_param.sv
// freepdk45_sram_1w1r_param
//   Parametrised one-write/one-read SRAM behavioural model for FreePDK45 OpenRAM
//   1w1r macros. After reset it runs a hardware sweep that writes zero to every
//   word, then serves writes (port 0) and registered reads (port 1).
//
// Optional feature macro: SRAM_COLLISION_BYPASS_EN
//   defined   : a same-edge read of the address being written returns the
//               write-first merge (masked lanes from din0, others from memory).
//   undefined : such a read returns the old word (read-first).
//
// Ports
//   clk0         clock, all state changes on the rising edge
//   rst0         synchronous active-high reset (memory contents untouched)
//   csb0         write select, active low
//   wmask0       per-lane write enable, lane i = din0[i*WRITE_SIZE +: WRITE_SIZE]
//   addr0, din0  write address / data
//   csb1         read select, active low
//   addr1        read address
//   dout1        registered read data, holds between reads
//   dout1_valid  one-cycle strobe marking a completed read
//   init_done    high once the zeroing sweep has finished
module freepdk45_sram_1w1r_param #(
  parameter  int DATA_WIDTH   = 124,
  parameter  int WRITE_SIZE   = 31,
  parameter  int ADDR_WIDTH   = 7,
  parameter  int READ_LATENCY = 1,
  localparam int NUM_WMASKS   = DATA_WIDTH / WRITE_SIZE,
  localparam int RAM_DEPTH    = 1 << ADDR_WIDTH
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  csb0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  output logic                  init_done
);

  if (DATA_WIDTH % WRITE_SIZE != 0) begin : g_bad_write_size
    $error("DATA_WIDTH must be a multiple of WRITE_SIZE");
  end

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  init_done_d;

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic                  init_clr;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_word;

  // Reset overrides everything, including port activity on the same edge.
  assign init_clr = (state_q == ST_INIT)  && !rst0;
  assign wr_en    = (state_q == ST_READY) && !rst0 && !csb0;
  assign rd_en    = (state_q == ST_READY) && !rst0 && !csb1;

  always_ff @(posedge clk0) begin
    if (rst0) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      init_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      init_done <= init_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done;
    unique case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d     = ST_READY;
          init_done_d = 1'b1;
        end
      end
      ST_READY: begin
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk0) begin
    if (init_clr) begin
      mem[cnt_q] <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
        if (wmask0[i]) begin
          mem[addr0][i*WRITE_SIZE +: WRITE_SIZE] <= din0[i*WRITE_SIZE +: WRITE_SIZE];
        end
      end
    end
  end

  always_comb begin
    rd_word = mem[addr1];
`ifdef SRAM_COLLISION_BYPASS_EN
    if (wr_en && (addr0 == addr1)) begin
      for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
        if (wmask0[i]) begin
          rd_word[i*WRITE_SIZE +: WRITE_SIZE] = din0[i*WRITE_SIZE +: WRITE_SIZE];
        end
      end
    end
`endif
  end

  if (READ_LATENCY == 1) begin : g_lat1
    always_ff @(posedge clk0) begin
      if (rst0) begin
        dout1       <= '0;
        dout1_valid <= 1'b0;
      end else begin
        dout1_valid <= rd_en;
        if (rd_en) begin
          dout1 <= rd_word;
        end
      end
    end
  end else if (READ_LATENCY == 2) begin : g_lat2
    logic                  stage_v;
    logic [DATA_WIDTH-1:0] stage_word;

    // Collision data is resolved when the read is accepted, so the extra
    // stage only delays an already-final word.
    always_ff @(posedge clk0) begin
      if (rst0) begin
        stage_v     <= 1'b0;
        dout1       <= '0;
        dout1_valid <= 1'b0;
      end else begin
        stage_v     <= rd_en;
        dout1_valid <= stage_v;
        if (rd_en) begin
          stage_word <= rd_word;
        end
        if (stage_v) begin
          dout1 <= stage_word;
        end
      end
    end
  end else begin : g_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end

endmodule
